// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares one single-port memory between the instruction-fetch requester and
// the load/store requester of a multicycle CPU.
// A request is latched in IDLE, issued for exactly one cycle in ISSUE, timed
// through WAIT by a 4-bit down-counter, and then completed with a one-cycle
// Done pulse to the owner in DONE.
// When both requesters ask in the same IDLE cycle, the one not granted last
// wins.
// Optional feature macro: MEM_ARB_POSTED_WRITE_EN. When it is defined, stores
// skip WAIT and complete in the cycle after ISSUE.
// LATENCY must lie in 1..15 so that LATENCY-1 fits the 4-bit counter.
module mem_access_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic              FetchDone,
  output logic [DATA_W-1:0] FetchData,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWData,
  output logic              DataDone,
  output logic [DATA_W-1:0] DataRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Busy,
  output logic              Owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Value loaded into the counter at ISSUE; it reaches zero in the last WAIT cycle.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;
  logic                owner_reg, owner_next;
  logic                last_owner_reg, last_owner_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic                we_reg, we_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   fetch_data_reg, fetch_data_next;
  logic [DATA_W-1:0]   data_rdata_reg, data_rdata_next;
  logic                grant_data;

  // State register and latched transaction fields; reset clears everything at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b0;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      fetch_data_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      addr_reg       <= addr_next;
      we_reg         <= we_next;
      wdata_reg      <= wdata_next;
      fetch_data_reg <= fetch_data_next;
      data_rdata_reg <= data_rdata_next;
    end
  end

  // Next-state logic: arbitration in IDLE, latency timing in WAIT, read-data capture.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    addr_next       = addr_reg;
    we_next         = we_reg;
    wdata_next      = wdata_reg;
    fetch_data_next = fetch_data_reg;
    data_rdata_next = data_rdata_reg;
    // Data wins a conflict only when fetch was granted last.
    grant_data      = DataReq && (!FetchReq || !last_owner_reg);

    case (state_reg)
      IDLE: begin
        if (FetchReq || DataReq) begin
          owner_next      = grant_data;
          last_owner_next = grant_data;
          addr_next       = grant_data ? DataAddr : FetchAddr;
          we_next         = grant_data && DataWe;
          wdata_next      = grant_data ? DataWData : '0;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next = CNT_LOAD;
`ifdef MEM_ARB_POSTED_WRITE_EN
        // Posted stores need no memory response, so they finish right away.
        state_next = we_reg ? DONE : WAIT;
`else
        state_next = WAIT;
`endif
      end
      WAIT: begin
        if (cnt_reg == 4'd0) begin
          // Only reads return data; a store leaves both data registers alone.
          if (!we_reg) begin
            if (owner_reg) data_rdata_next = MemRData;
            else           fetch_data_next = MemRData;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        // Request levels seen here are ignored; IDLE re-samples them.
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and the latched fields; strobes only during ISSUE.
  always_comb begin
    MemAddr   = addr_reg;
    MemWData  = wdata_reg;
    MemRead   = (state_reg == ISSUE) && !we_reg;
    MemWrite  = (state_reg == ISSUE) && we_reg;
    FetchDone = (state_reg == DONE) && !owner_reg;
    DataDone  = (state_reg == DONE) && owner_reg;
    FetchData = fetch_data_reg;
    DataRData = data_rdata_reg;
    Busy      = (state_reg != IDLE);
    Owner     = owner_reg;
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: one instance at LATENCY=2 and one at
// LATENCY=1. Each instance has a memory model that presents valid read data
// only in the cycle exactly LATENCY cycles after the read strobe; every other
// cycle it returns a junk pattern.
module tb_mem_access_arbiter;

  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;
`ifdef MEM_ARB_POSTED_WRITE_EN
  localparam int STORE_CYC = 2;
`else
  localparam int STORE_CYC = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, data_req, data_we, l1_data_req;
  logic [31:0] fetch_addr, data_addr, data_wdata;
  logic        fetch_done, data_done, mem_read, mem_write, busy, owner;
  logic [31:0] fetch_data, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        l1_fetch_done, l1_data_done, l1_mem_read, l1_mem_write, l1_busy, l1_owner;
  logic [31:0] l1_fetch_data, l1_data_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [31:0] p2 [0:1];
  logic [31:0] p1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2)) u_dut (
    .Clk(clk), .Reset_n(rst_n),
    .FetchReq(fetch_req), .FetchAddr(fetch_addr), .FetchDone(fetch_done), .FetchData(fetch_data),
    .DataReq(data_req), .DataWe(data_we), .DataAddr(data_addr), .DataWData(data_wdata),
    .DataDone(data_done), .DataRData(data_rdata),
    .MemAddr(mem_addr), .MemRead(mem_read), .MemWrite(mem_write), .MemWData(mem_wdata),
    .MemRData(mem_rdata), .Busy(busy), .Owner(owner)
  );

  mem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1)) u_l1 (
    .Clk(clk), .Reset_n(rst_n),
    .FetchReq(1'b0), .FetchAddr(fetch_addr), .FetchDone(l1_fetch_done), .FetchData(l1_fetch_data),
    .DataReq(l1_data_req), .DataWe(data_we), .DataAddr(data_addr), .DataWData(data_wdata),
    .DataDone(l1_data_done), .DataRData(l1_data_rdata),
    .MemAddr(l1_mem_addr), .MemRead(l1_mem_read), .MemWrite(l1_mem_write), .MemWData(l1_mem_wdata),
    .MemRData(l1_mem_rdata), .Busy(l1_busy), .Owner(l1_owner)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0], 16'hA5A5};
  endfunction

  // Memory models: read data appears exactly LATENCY cycles after the strobe cycle.
  always @(posedge clk) begin
    p2[0] <= mem_read ? mem_word(mem_addr) : JUNK;
    p2[1] <= p2[0];
    p1    <= l1_mem_read ? mem_word(l1_mem_addr) : JUNK;
  end
  assign mem_rdata    = p2[1];
  assign l1_mem_rdata = p1;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clock until the target Done pulses, counting strobes and foreign Done pulses.
  task automatic run_until_done(input int dut, input bit tgt, input int limit,
                                output int cyc, output int nrd, output int nwr,
                                output int nother, output logic [31:0] saddr,
                                output logic [31:0] swd);
    logic mr, mw, fd, dd;
    cyc = -1; nrd = 0; nwr = 0; nother = 0; saddr = '0; swd = '0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      mr = (dut == 0) ? mem_read   : l1_mem_read;
      mw = (dut == 0) ? mem_write  : l1_mem_write;
      fd = (dut == 0) ? fetch_done : l1_fetch_done;
      dd = (dut == 0) ? data_done  : l1_data_done;
      if (mr) nrd++;
      if (mw) nwr++;
      if (mr || mw) begin
        saddr = (dut == 0) ? mem_addr  : l1_mem_addr;
        swd   = (dut == 0) ? mem_wdata : l1_mem_wdata;
      end
      if (tgt ? fd : dd) nother++;
      if (tgt ? dd : fd) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc, nrd, nwr, nother, extra_rd, extra_done;
    logic [31:0] saddr, swd;

    rst_n = 1'b0; fetch_req = 0; data_req = 0; data_we = 0; l1_data_req = 0;
    fetch_addr = '0; data_addr = '0; data_wdata = '0;
    p2[0] = JUNK; p2[1] = JUNK; p1 = JUNK;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_memread", {31'd0, mem_read}, 32'd0);
    chk("rst_memwrite", {31'd0, mem_write}, 32'd0);
    chk("rst_memaddr", mem_addr, 32'd0);
    chk("rst_fetchdata", fetch_data, 32'd0);
    chk("rst_datardata", data_rdata, 32'd0);
    chk("rst_fetchdone", {31'd0, fetch_done}, 32'd0);

    // Single fetch of 0x40
    fetch_req = 1; fetch_addr = 32'h40;
    run_until_done(0, 1'b0, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("fetch_cyc", cyc, 32'd4);
    chk("fetch_nrd", nrd, 32'd1);
    chk("fetch_nwr", nwr, 32'd0);
    chk("fetch_addr", saddr, 32'h40);
    chk("fetch_data", fetch_data, 32'h8C22_0004);
    chk("fetch_owner", {31'd0, owner}, 32'd0);
    chk("fetch_other", nother, 32'd0);
    fetch_req = 0;
    tick();
    chk("fetch_done_clr", {31'd0, fetch_done}, 32'd0);
    chk("fetch_data_hold", fetch_data, 32'h8C22_0004);
    chk("fetch_idle", {31'd0, busy}, 32'd0);

    // First conflict: data wins
    fetch_req = 1; fetch_addr = 32'h44;
    data_req = 1; data_we = 0; data_addr = 32'h200;
    run_until_done(0, 1'b1, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("conf1_data_cyc", cyc, 32'd4);
    chk("conf1_data_other", nother, 32'd0);
    chk("conf1_data_rdata", data_rdata, 32'h0200_A5A5);
    chk("conf1_data_owner", {31'd0, owner}, 32'd1);
    chk("conf1_fetch_untouched", fetch_data, 32'h8C22_0004);
    data_req = 0;
    run_until_done(0, 1'b0, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("conf1_fetch_cyc", cyc, 32'd5);
    chk("conf1_fetch_data", fetch_data, 32'h0044_A5A5);
    chk("conf1_fetch_addr", saddr, 32'h44);
    fetch_req = 0;
    tick();

    // Store
    data_req = 1; data_we = 1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF;
    run_until_done(0, 1'b1, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("store_cyc", cyc, STORE_CYC);
    chk("store_nwr", nwr, 32'd1);
    chk("store_nrd", nrd, 32'd0);
    chk("store_addr", saddr, 32'h100);
    chk("store_wdata", swd, 32'hDEAD_BEEF);
    chk("store_rdata_kept", data_rdata, 32'h0200_A5A5);
    chk("store_fetch_kept", fetch_data, 32'h0044_A5A5);
    data_req = 0; data_we = 0;
    tick();

    // Second conflict: fetch wins after the data grant
    fetch_req = 1; fetch_addr = 32'h48;
    data_req = 1; data_addr = 32'h300;
    run_until_done(0, 1'b0, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("conf2_fetch_cyc", cyc, 32'd4);
    chk("conf2_fetch_data", fetch_data, 32'h0048_A5A5);
    chk("conf2_fetch_other", nother, 32'd0);
    fetch_req = 0;
    run_until_done(0, 1'b1, 12, cyc, nrd, nwr, nother, saddr, swd);
    chk("conf2_data_cyc", cyc, 32'd5);
    chk("conf2_data_rdata", data_rdata, 32'h0300_A5A5);
    data_req = 0;
    tick();

    // Stability: address change and request drop during WAIT
    fetch_req = 1; fetch_addr = 32'h80;
    tick();
    chk("stab_issue_rd", {31'd0, mem_read}, 32'd1);
    chk("stab_issue_addr", mem_addr, 32'h80);
    tick();
    fetch_addr = 32'hFC; fetch_req = 0;
    chk("stab_wait_rd", {31'd0, mem_read}, 32'd0);
    chk("stab_wait_addr", mem_addr, 32'h80);
    run_until_done(0, 1'b0, 10, cyc, nrd, nwr, nother, saddr, swd);
    chk("stab_cyc", cyc, 32'd2);
    chk("stab_data", fetch_data, 32'h0080_A5A5);
    extra_rd = 0; extra_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_read || mem_write) extra_rd++;
      if (fetch_done) extra_done++;
    end
    chk("stab_no_reissue", extra_rd, 32'd0);
    chk("stab_single_done", extra_done, 32'd0);
    chk("stab_idle", {31'd0, busy}, 32'd0);

    // LATENCY=1 load
    l1_data_req = 1; data_we = 0; data_addr = 32'h40;
    run_until_done(1, 1'b1, 10, cyc, nrd, nwr, nother, saddr, swd);
    chk("l1_cyc", cyc, 32'd3);
    chk("l1_nrd", nrd, 32'd1);
    chk("l1_rdata", l1_data_rdata, 32'h8C22_0004);
    l1_data_req = 0;
    tick();

    // Reset in the middle of WAIT
    fetch_req = 1; fetch_addr = 32'h40;
    tick();
    tick();
    chk("rstw_busy_before", {31'd0, busy}, 32'd1);
    fetch_req = 0;
    rst_n = 1'b0;
    #2;
    chk("rstw_memread", {31'd0, mem_read}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    chk("rstw_fetchdata", fetch_data, 32'd0);
    chk("rstw_datardata", data_rdata, 32'd0);
    chk("rstw_memaddr", mem_addr, 32'd0);
    extra_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fetch_done) extra_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (fetch_done) extra_done++;
    end
    chk("rstw_no_done", extra_done, 32'd0);
    chk("rstw_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequences the multicycle CPU's single-port memory and shares it between the instruction-fetch requester and the load/store requester. It sits between the control unit and the memory. The block absorbs the memory's fixed read latency, so the control unit issues one request and waits for a one-cycle done pulse instead of stepping through its own delay states. Requests are latched, issued once, timed with a down-counter and completed with a done pulse to the owning requester.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LATENCY, 2, memory read latency in cycles; legal range 1..15
- Clk  in  1  system clock, all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- FetchReq  in  1  fetch read request; level, held until FetchDone
- FetchAddr  in  ADDR_W  fetch address
- FetchDone  out  1  one-cycle completion pulse to fetch
- FetchData  out  DATA_W  fetched word, valid while FetchDone=1, held afterwards
- DataReq  in  1  load/store request; level, held until DataDone
- DataWe  in  1  1=store, 0=load
- DataAddr  in  ADDR_W  load/store address
- DataWData  in  DATA_W  store data
- DataDone  out  1  one-cycle completion pulse to load/store
- DataRData  out  DATA_W  load word, valid while DataDone=1, held afterwards
- MemAddr  out  ADDR_W  memory address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- MemWData  out  DATA_W  memory write data
- MemRData  in  DATA_W  memory read data, valid LATENCY cycles after the read strobe cycle
- Busy  out  1  1 in every state except IDLE
- Owner  out  1  current or last grantee: 0=fetch, 1=data

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - If only one request is high, grant it.
  - If both are high, grant the requester that was not granted last. LastOwner resets to 0, so the first conflict goes to data.
  - On grant: latch address, We (forced 0 for fetch) and write data; set Owner and LastOwner; go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Drive MemAddr/MemWData from the latched values. MemRead = !We, MemWrite = We.
  - Load Cnt = LATENCY-1 and go to WAIT.
- **WAIT**
  - MemRead/MemWrite = 0. MemAddr holds the latched address.
  - Decrement Cnt each cycle.
  - When Cnt==0: capture MemRData into the owner's data register (loads/fetches only; stores capture nothing), then go to DONE.
- **DONE** (exactly 1 cycle)
  - Pulse the owner's Done; go unconditionally to IDLE.
  - Request levels sampled during DONE are ignored.
- Requester obligations:
  - Deassert Req no later than the cycle after Done.
  - A Req still high in IDLE is treated as a new request.
- Dropping Req mid-transaction has no effect: the transaction completes and Done still pulses.
- Input changes after the grant are ignored because all fields are latched.
- The data registers of the non-owning requester never change.

## Timing
- Reset values: all outputs 0; FetchData = DataRData = 0; state IDLE; Cnt = 0; LastOwner = 0.
- Reset_n low at any time forces these values immediately. This includes mid-WAIT: the strobe is removed and no Done is issued.
- Request sampled at edge E0 → ISSUE in cycle 1, WAIT in cycles 2..LATENCY+1, DONE in cycle LATENCY+2.
- Latency from request to Done is LATENCY+2 cycles (4 cycles at LATENCY=2). Stores take the same time unless the posted-write feature is enabled.
- Minimum spacing between grants is LATENCY+3 cycles (IDLE is always visited).
- MemRead/MemWrite are never both 1 and are high for exactly one cycle per transaction.
- Counter is 4 bits. LATENCY=1 gives a single WAIT cycle, with no wrap-around.

## Configuration
- Macro: MEM_ARB_POSTED_WRITE_EN.
- **Defined:** a store goes ISSUE → DONE directly. DataDone pulses in the cycle after ISSUE (store latency 2 cycles) and WAIT is skipped. Loads and fetches are unchanged.
- **Undefined:** stores traverse WAIT like reads, which gives uniform LATENCY+2 timing.

## Test plan
- **Reset:** Reset_n=0 mid-WAIT of a fetch → MemRead=0, Busy=0, FetchDone never pulses, FetchData=0.
- **Single fetch:** FetchReq=1, FetchAddr=0x40, LATENCY=2, memory returns 0x8C220004.
  - MemRead=1 with MemAddr=0x40 for one cycle.
  - FetchDone pulses 4 cycles after the sampling edge with FetchData=0x8C220004.
- **Conflict:** FetchReq and DataReq rise together.
  - Data is granted first; fetch is granted on the next IDLE.
  - A second simultaneous conflict grants fetch first.
- **Store:** DataWe=1, DataAddr=0x100, DataWData=0xDEADBEEF.
  - One MemWrite cycle with those values.
  - DataDone after 4 cycles, or after 2 with MEM_ARB_POSTED_WRITE_EN; DataRData unchanged.
- **Stability:** FetchAddr changes and FetchReq drops during WAIT → the original address is held, FetchDone still pulses once, and no second request is issued.
- **LATENCY=1:** load completes in 3 cycles, capturing MemRData in the single WAIT cycle.
